// File: rtl/cov_pkg.sv
// Shared types and constants for the covariance result buffer.
package cov_pkg;

    // Number of upper-triangle (including diagonal) products for nch*nt taps.
    function automatic int maccs_num(input int nch, input int nt);
        int n;
        n = nch * nt;
        return (n * n - n) / 2 + n;
    endfunction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        COPY = 2'd1,
        PEND = 2'd2
    } cov_buf_state_t;

    // Extra samples beyond MACCS_NUM a window must span so a copy can
    // finish and publish before the next dump arrives.
    localparam int CLAMP_MARGIN = 2;

endpackage

// File: rtl/cov_bank_ram.sv
// Simple dual-port RAM holding both ping-pong banks; registered read port.
module cov_bank_ram #(
    parameter int DEPTH  = 420,
    parameter int WIDTH  = 32,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Synchronous write and registered read; one port each.
    // NOTE: neither the array nor the read register is reset, which keeps this mappable onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/cov_result_buffer.sv
// Integration-window timer, ping-pong frame capture and host read port for cov_matrix.
module cov_result_buffer
    import cov_pkg::*;
#(
    parameter int NCH         = 2,
    parameter int NT          = 10,
    parameter int MACCS_NUM   = maccs_num(NCH, NT),
    parameter int ACCUM_WIDTH = 32,
    parameter int AW          = $clog2(MACCS_NUM),
    parameter int CNT_WIDTH   = 32
) (
    input  logic                             clk,
    input  logic                             resetn,
    input  logic                             ce,
    input  logic                             enable,
    input  logic [CNT_WIDTH-1:0]             win_len,
    input  logic [MACCS_NUM*ACCUM_WIDTH-1:0] acc_in,
    output logic                             acc_dump,
    input  logic                             rd_en,
    input  logic [AW-1:0]                    rd_addr,
    output logic [ACCUM_WIDTH-1:0]           rd_data,
    output logic                             rd_valid,
    input  logic                             done_ack,
    output logic                             data_ready,
    output logic [15:0]                      frame_cnt,
    output logic [15:0]                      drop_cnt
);

    localparam int RAM_DEPTH = 2 * MACCS_NUM;
    localparam int RAM_AW    = $clog2(RAM_DEPTH);
    localparam logic [CNT_WIDTH-1:0] MIN_LEN  = CNT_WIDTH'(MACCS_NUM + CLAMP_MARGIN);
    localparam logic [AW-1:0]        LAST_IDX = AW'(MACCS_NUM - 1);
    localparam logic [RAM_AW-1:0]    BANK1    = RAM_AW'(MACCS_NUM);

    cov_buf_state_t         state;
    logic [AW-1:0]          idx;
    logic                   rbank;
    logic [CNT_WIDTH-1:0]   cnt;
    logic [CNT_WIDTH-1:0]   eff_len;
    logic                   wrap;
    logic                   in_range;
    logic                   rd_oob;
    logic                   wr_en;
    logic [RAM_AW-1:0]      wr_addr;
    logic [RAM_AW-1:0]      ram_rd_addr;
    logic [ACCUM_WIDTH-1:0] ram_q;
    logic [ACCUM_WIDTH-1:0] acc_words [MACCS_NUM];

    for (genvar k = 0; k < MACCS_NUM; k++) begin : g_words
        assign acc_words[k] = acc_in[k*ACCUM_WIDTH +: ACCUM_WIDTH];
    end

    // Short windows are stretched so the copy always finishes in time.
    assign eff_len = (win_len < MIN_LEN) ? MIN_LEN : win_len;
    // ">=" rather than "==" so shrinking win_len below cnt wraps on the next sample.
    assign wrap    = (cnt >= eff_len - CNT_WIDTH'(1));

    // The write bank is always the one the host is not reading.
    assign wr_en       = (state == COPY);
    assign wr_addr     = (rbank ? '0 : BANK1) + RAM_AW'(idx);
    assign in_range    = ({1'b0, rd_addr} < (AW+1)'(MACCS_NUM));
    assign ram_rd_addr = (rbank ? BANK1 : '0) + RAM_AW'(rd_addr);
    assign rd_data     = (rd_valid && !rd_oob) ? ram_q : '0;

    cov_bank_ram #(
        .DEPTH  (RAM_DEPTH),
        .WIDTH  (ACCUM_WIDTH),
        .ADDR_W (RAM_AW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (acc_words[idx]),
        .rd_en   (rd_en && in_range),
        .rd_addr (ram_rd_addr),
        .rd_data (ram_q)
    );

    // Window counter: counts qualified samples and emits a one-clock dump pulse.
    // NOTE: registered state uses non-blocking assignments so every block sees pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt      <= '0;
            acc_dump <= 1'b0;
        end else begin
            acc_dump <= 1'b0;
            if (!enable) begin
                cnt <= '0;
            end else if (ce) begin
                if (wrap) begin
                    cnt      <= '0;
                    acc_dump <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    // Copy FSM, bank swap, host handshake and frame/drop accounting.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            idx        <= '0;
            rbank      <= 1'b0;
            data_ready <= 1'b0;
            frame_cnt  <= '0;
            drop_cnt   <= '0;
        end else begin
            // A release clears the flag unless a swap below republishes this cycle.
            if (done_ack && data_ready) begin
                data_ready <= 1'b0;
            end
            // cov_matrix clears regardless, so a dump we cannot take is lost.
            if (acc_dump && state != IDLE && drop_cnt != 16'hFFFF) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
            case (state)
                IDLE: begin
                    if (acc_dump) begin
                        state <= COPY;
                        idx   <= '0;
                    end
                end
                COPY: begin
                    idx <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        state <= PEND;
                    end
                end
                PEND: begin
                    if (!data_ready || done_ack) begin
                        rbank      <= ~rbank;
                        data_ready <= 1'b1;
                        frame_cnt  <= frame_cnt + 16'd1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read strobe pipeline aligned with the RAM's registered output.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_valid <= 1'b0;
            rd_oob   <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            rd_oob   <= !in_range;
        end
    end

endmodule

// File: tb/tb_cov_result_buffer.sv
// Self-checking bench for cov_result_buffer: directed corner cases plus a randomized run against a reference model.
module tb_cov_result_buffer;

    localparam int M  = 210;
    localparam int W  = 32;
    localparam int LMIN = M + 2;

    logic             clk = 1'b0;
    logic             resetn = 1'b1;
    logic             ce = 1'b0;
    logic             enable = 1'b0;
    logic [31:0]      win_len = 32'd1000;
    logic [M*W-1:0]   acc_in = '0;
    logic             acc_dump;
    logic             rd_en = 1'b0;
    logic [7:0]       rd_addr = '0;
    logic [W-1:0]     rd_data;
    logic             rd_valid;
    logic             done_ack = 1'b0;
    logic             data_ready;
    logic [15:0]      frame_cnt;
    logic [15:0]      drop_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    cov_result_buffer dut (
        .clk        (clk),
        .resetn     (resetn),
        .ce         (ce),
        .enable     (enable),
        .win_len    (win_len),
        .acc_in     (acc_in),
        .acc_dump   (acc_dump),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .done_ack   (done_ack),
        .data_ready (data_ready),
        .frame_cnt  (frame_cnt),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (event/time based) ----------------
    longint      t = 0;
    int unsigned m_cnt;
    bit          m_dump, m_ready, m_busy, m_rv, m_rd_known, rbank_known;
    bit [15:0]   m_frame, m_drop;
    longint      m_pub_at;
    logic [31:0] m_rd;
    logic [31:0] cur_words   [M];
    logic [31:0] pend_words  [M];
    logic [31:0] rbank_words [M];
    int          pattern = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h t=%0d", name, act, exp, t);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_dump = 0; m_ready = 0; m_busy = 0; m_rv = 0;
        m_frame = 0; m_drop = 0; rbank_known = 0; m_rd_known = 0;
    endtask

    // One clock edge of the specified behaviour, evaluated on pre-edge inputs.
    task automatic model_edge(output bit new_words);
        bit          dump_now, busy_pre;
        int unsigned len;
        t++;
        dump_now  = m_dump;
        busy_pre  = m_busy;
        new_words = 0;
        m_rv       = rd_en;
        m_rd_known = (rd_addr >= M) || rbank_known;
        m_rd       = (rd_addr < M) ? rbank_words[rd_addr] : 32'd0;
        if (m_busy && t >= m_pub_at && (!m_ready || done_ack)) begin
            rbank_words = pend_words;
            rbank_known = 1;
            m_ready = 1; m_frame++; m_busy = 0;
        end else if (done_ack && m_ready) begin
            m_ready = 0;
        end
        if (dump_now) begin
            for (int k = 0; k < M; k++) cur_words[k] = (pattern == 1) ? 32'(k + 1) : $urandom;
            new_words = 1;
            if (busy_pre) begin
                if (m_drop != 16'hFFFF) m_drop++;
            end else begin
                m_busy = 1;
                m_pub_at = t + M + 1;
                pend_words = cur_words;
            end
        end
        len = (win_len < LMIN) ? LMIN : win_len;
        m_dump = 0;
        if (!enable) m_cnt = 0;
        else if (ce) begin
            if (m_cnt + 1 >= len) begin m_cnt = 0; m_dump = 1; end
            else m_cnt++;
        end
    endtask

    task automatic tick();
        bit nw;
        @(posedge clk);
        model_edge(nw);
        #1;
        if (nw) for (int k = 0; k < M; k++) acc_in[k*W +: W] = cur_words[k];
        check("acc_dump", 32'(acc_dump), 32'(m_dump));
        check("data_ready", 32'(data_ready), 32'(m_ready));
        check("frame_cnt", 32'(frame_cnt), 32'(m_frame));
        check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
        check("rd_valid", 32'(rd_valid), 32'(m_rv));
        if (m_rv && m_rd_known) check("rd_data", rd_data, m_rd);
    endtask

    task automatic do_reset();
        rd_en = 0; done_ack = 0;
        resetn = 1'b0;
        #1;
        check("rst_acc_dump", 32'(acc_dump), 0);
        check("rst_data_ready", 32'(data_ready), 0);
        check("rst_frame_cnt", 32'(frame_cnt), 0);
        check("rst_drop_cnt", 32'(drop_cnt), 0);
        check("rst_rd_valid", 32'(rd_valid), 0);
        check("rst_rd_data", rd_data, 0);
        model_reset();
        @(posedge clk); @(posedge clk); @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic wait_dump(input string name, input int limit, input bit toggle, output int n);
        n = 0;
        do begin
            if (toggle) ce = ~ce;
            tick();
            n++;
        end while (!acc_dump && n < limit);
        check({name, "_seen"}, 32'(acc_dump), 1);
    endtask

    task automatic wait_ready(input string name, input int limit, output int n);
        n = 0;
        do begin tick(); n++; end while (!data_ready && n < limit);
        check({name, "_seen"}, 32'(data_ready), 1);
    endtask

    typedef struct {
        bit          en;
        logic [7:0]  addr;
        bit          exp_valid;
        logic [31:0] exp_data;
    } rd_vec_t;

    rd_vec_t rd_tab [8];

    initial begin
        int n, dumps;
        logic [31:0] old_word;

        rd_tab[0] = '{1, 8'd0,   1, 32'd1};
        rd_tab[1] = '{1, 8'd1,   1, 32'd2};
        rd_tab[2] = '{0, 8'd1,   0, 32'd0};
        rd_tab[3] = '{1, 8'd100, 1, 32'd101};
        rd_tab[4] = '{1, 8'd209, 1, 32'd210};
        rd_tab[5] = '{1, 8'd210, 1, 32'd0};
        rd_tab[6] = '{1, 8'd255, 1, 32'd0};
        rd_tab[7] = '{0, 8'd0,   0, 32'd0};

        #2;
        do_reset();

        // Single frame with incrementing words.
        win_len = 1000; ce = 1; enable = 1; pattern = 1;
        wait_dump("single_dump", 2000, 0, n);
        check("single_dump_clock", n, 1000);
        enable = 0;   // copy must still complete and publish
        wait_ready("single_ready", 400, n);
        check("single_ready_latency", n, M + 2);
        check("single_frame_cnt", 32'(frame_cnt), 1);
        for (int i = 0; i < 8; i++) begin
            rd_en = rd_tab[i].en; rd_addr = rd_tab[i].addr;
            tick();
            check("tab_rd_valid", 32'(rd_valid), 32'(rd_tab[i].exp_valid));
            if (rd_tab[i].exp_valid) check("tab_rd_data", rd_data, rd_tab[i].exp_data);
        end
        rd_en = 0; pattern = 0;

        // Clamp: short win_len stretched to MACCS_NUM+2 samples.
        win_len = 5; enable = 1; ce = 1;
        wait_dump("clamp1", 1000, 0, n);
        check("clamp_first_period", n, LMIN);
        wait_dump("clamp2", 1000, 0, n);
        check("clamp_period", n, LMIN);
        wait_dump("clamp_tog1", 1000, 1, n);
        check("clamp_toggle_period1", n, 2 * LMIN);
        wait_dump("clamp_tog2", 1000, 1, n);
        check("clamp_toggle_period2", n, 2 * LMIN);
        ce = 1;

        // Backpressure: three windows without release.
        do_reset();
        win_len = 300; ce = 1; enable = 1;
        for (int w = 0; w < 3; w++) wait_dump("bp", 1000, 0, n);
        tick(); tick();
        check("bp_frame_cnt", 32'(frame_cnt), 1);
        check("bp_drop_cnt", 32'(drop_cnt), 1);
        check("bp_data_ready", 32'(data_ready), 1);
        enable = 0;
        for (int i = 0; i < 5; i++) tick();
        done_ack = 1; tick(); done_ack = 0;
        check("bp_ack_frame_cnt", 32'(frame_cnt), 2);
        check("bp_ack_data_ready", 32'(data_ready), 1);

        // Release coincident with the swap, plus a read in that cycle.
        old_word = rbank_words[5];
        enable = 1;
        wait_dump("sim_dump", 1000, 0, n);
        enable = 0;
        for (int i = 0; i < M + 1; i++) tick();
        done_ack = 1; rd_en = 1; rd_addr = 8'd5;
        tick();
        done_ack = 0; rd_en = 0;
        check("sim_frame_cnt", 32'(frame_cnt), 3);
        check("sim_data_ready", 32'(data_ready), 1);
        check("sim_drop_cnt", 32'(drop_cnt), 1);
        check("sim_old_bank_read", rd_data, old_word);
        rd_en = 1; rd_addr = 8'd5; tick(); rd_en = 0;
        check("sim_new_bank_read", rd_data, rbank_words[5]);

        // Enable drop at cnt=500, then reset mid-copy.
        do_reset();
        win_len = 1000; enable = 1; ce = 1;
        for (int i = 0; i < 500; i++) tick();
        enable = 0; dumps = 0;
        for (int i = 0; i < 1200; i++) begin tick(); if (acc_dump) dumps++; end
        check("en_off_no_dump", dumps, 0);
        enable = 1;
        wait_dump("en_restart", 2000, 0, n);
        check("en_restart_from_zero", n, 1000);
        wait_ready("en_pub", 400, n);
        wait_dump("en_dump2", 2000, 0, n);
        for (int i = 0; i < 50; i++) tick();
        check("pre_rst_frame_cnt", 32'(frame_cnt), 1);
        do_reset();
        enable = 0;
        for (int i = 0; i < 300; i++) tick();
        check("post_rst_no_publish", 32'(frame_cnt), 0);

        // Saturation and wrap.
        do_reset();
        win_len = 5; enable = 1; ce = 1;
        wait_dump("sat_d1", 1000, 0, n);
        wait_ready("sat_pub", 400, n);
        tick(); tick();
        force dut.drop_cnt = 16'hFFFE;
        force dut.frame_cnt = 16'hFFFF;
        m_drop = 16'hFFFE; m_frame = 16'hFFFF;
        tick();
        release dut.drop_cnt;
        release dut.frame_cnt;
        tick();
        wait_dump("sat_d3", 1000, 0, n); tick();
        check("sat_drop_ffff", 32'(drop_cnt), 32'hFFFF);
        wait_dump("sat_d4", 1000, 0, n); tick();
        check("sat_drop_hold", 32'(drop_cnt), 32'hFFFF);
        enable = 0;
        done_ack = 1; tick(); done_ack = 0;
        check("frame_wrap", 32'(frame_cnt), 0);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 6000; i++) begin
            if (i % 500 == 0) begin
                win_len = ($urandom % 3 == 0) ? 32'd5 : 32'(LMIN + $urandom % 60);
                enable  = ($urandom % 5) != 0;
            end
            ce       = ($urandom % 4) != 0;
            done_ack = ($urandom % 40) == 0;
            rd_en    = ($urandom % 3) == 0;
            rd_addr  = 8'($urandom);
            tick();
        end
        rd_en = 0; done_ack = 0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
